// File: rtl/mc_control_fsm.sv
// -----------------------------------------------------------------------------
// mc_control_fsm
//
// Multicycle main control FSM for the ARM datapath (data-processing, LDR/STR,
// B). Moves one instruction through FETCH, DECODE and its execute states. It
// drives the per-cycle datapath selects and the raw RegW/MemW/Branch strobes,
// which the downstream condition stage gates with CondEx.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   Op         instr[27:26]: 00 data-proc, 01 memory, 10 branch, 11 illegal
//   Funct      instr[25:20]; Funct[5] = I (immediate), Funct[0] = L (load)
//   MemReady   the memory access completes this cycle
//   IRWrite    load the instruction register
//   NextPC     write PC+4
//   AdrSrc     memory address: 0 = PC, 1 = ALU result register
//   ALUSrcA    00 reg A, 01 PC, 10 ALUOut
//   ALUSrcB    00 reg B, 01 ExtImm, 10 constant 4
//   ResultSrc  00 ALUOut, 01 ReadData, 10 ALUResult
//   ALUOp      1: the ALU decoder uses Funct; 0: add
//   RegW       raw register-write strobe
//   MemW       raw memory-write strobe
//   Branch     raw branch strobe (becomes PCS)
//   InstrDone  one-cycle pulse on the final cycle of an instruction
//   Illegal    sticky flag, set when DECODE sees Op=11; cleared only by reset
//   State      current state code (debug)
// -----------------------------------------------------------------------------
module mc_control_fsm (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic       MemReady,
  output logic       IRWrite,
  output logic       NextPC,
  output logic       AdrSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       ALUOp,
  output logic       RegW,
  output logic       MemW,
  output logic       Branch,
  output logic       InstrDone,
  output logic       Illegal,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9
  } state_t;

  state_t state;

  // Funct[4:1] is the ALU command. The ALU decoder consumes it, not this FSM.
  logic unused_funct;
  assign unused_funct = ^Funct[4:1];

  assign State = state;

  // NOTE: state registers use non-blocking assignments. Every flop then
  // samples pre-edge values, whatever order the simulator runs the blocks in.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= FETCH;
      Illegal <= 1'b0;
    end else begin
      case (state)
        FETCH:    if (MemReady) state <= DECODE;
        DECODE: begin
          case (Op)
            2'b00: begin
              if (Funct[5]) state <= EXECUTEI;
              else          state <= EXECUTER;
            end
            2'b01:   state <= MEMADR;
            2'b10:   state <= BRANCH;
            default: begin
              // Abandon the instruction and remember that it happened.
              state   <= FETCH;
              Illegal <= 1'b1;
            end
          endcase
        end
        MEMADR: begin
          if (Funct[0]) state <= MEMREAD;
          else          state <= MEMWRITE;
        end
        MEMREAD:            if (MemReady) state <= MEMWB;
        MEMWRITE:           if (MemReady) state <= FETCH;
        EXECUTER, EXECUTEI: state <= ALUWB;
        MEMWB, ALUWB, BRANCH: state <= FETCH;
        // Codes 10-15 are unreachable; recover to a clean fetch.
        default:            state <= FETCH;
      endcase
    end
  end

  // Moore decode of the current state. In FETCH and MEMWRITE, MemReady also
  // gates the strobes. A stalled fetch then writes the IR/PC exactly once, on
  // the cycle the read returns.
  always_comb begin
    // NOTE: every output gets a default before the case. A path that leaves
    // an output unassigned would otherwise infer a latch.
    IRWrite   = 1'b0;
    NextPC    = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    ALUOp     = 1'b0;
    RegW      = 1'b0;
    MemW      = 1'b0;
    Branch    = 1'b0;
    InstrDone = 1'b0;
    case (state)
      FETCH: begin
        AdrSrc    = 1'b0;
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = MemReady;
        NextPC    = MemReady;
      end
      DECODE: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        InstrDone = (Op == 2'b11);
      end
      MEMADR: begin
        ALUSrcA = 2'b00;
        ALUSrcB = 2'b01;
      end
      MEMREAD: begin
        AdrSrc    = 1'b1;
        ResultSrc = 2'b00;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        RegW      = 1'b1;
        InstrDone = 1'b1;
      end
      MEMWRITE: begin
        AdrSrc    = 1'b1;
        MemW      = 1'b1;
        InstrDone = MemReady;
      end
      EXECUTER: begin
        ALUSrcB = 2'b00;
        ALUOp   = 1'b1;
      end
      EXECUTEI: begin
        ALUSrcB = 2'b01;
        ALUOp   = 1'b1;
      end
      ALUWB: begin
        ResultSrc = 2'b00;
        RegW      = 1'b1;
        InstrDone = 1'b1;
      end
      BRANCH: begin
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        Branch    = 1'b1;
        InstrDone = 1'b1;
      end
      default: ;
    endcase
    // The async reset already forces state to FETCH. Masking the strobes here
    // as well keeps a write from escaping in the cycle reset arrives.
    if (!reset) begin
      IRWrite   = 1'b0;
      NextPC    = 1'b0;
      RegW      = 1'b0;
      MemW      = 1'b0;
      Branch    = 1'b0;
      InstrDone = 1'b0;
    end
  end

endmodule
